// File: rtl/alu_operand_stage_pkg.sv
// Shared opcode encodings and operand-select decode for the execute-stage operand unit.
package alu_operand_stage_pkg;

  localparam int OPW_DEF = 6;

  localparam logic [OPW_DEF-1:0] OP_IROP  = 6'h00;
  localparam logic [OPW_DEF-1:0] OP_IJ    = 6'h02;
  localparam logic [OPW_DEF-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPW_DEF-1:0] OP_BNE   = 6'h05;
  localparam logic [OPW_DEF-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPW_DEF-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPW_DEF-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPW_DEF-1:0] OP_ORI   = 6'h0D;

  typedef enum logic [1:0] {
    SEL_REG  = 2'd0,
    SEL_ZERO = 2'd1,
    SEL_IMM  = 2'd2
  } opnd_sel_e;

  // Anything not recognised as register/jump/branch is treated as an immediate op.
  function automatic opnd_sel_e sel_a(input logic [OPW_DEF-1:0] op);
    if (op == OP_IROP)    return SEL_REG;
    else if (op == OP_IJ) return SEL_ZERO;
    else                  return SEL_IMM;
  endfunction

  function automatic opnd_sel_e sel_b(input logic [OPW_DEF-1:0] op);
    if (op == OP_IROP || op == OP_BEQ || op == OP_BNE) return SEL_REG;
    else if (op == OP_IJ)                              return SEL_ZERO;
    else                                               return SEL_IMM;
  endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Priority forwarding mux: the lowest-index matching source wins; register 0 is never forwarded.
module operand_fwd_mux #(
  parameter int XLEN = 32,
  parameter int RIDX = 5,
  parameter int NFWD = 2
) (
  input  logic [RIDX-1:0]      src,
  input  logic [XLEN-1:0]      reg_val,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RIDX-1:0] fwd_dst,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic [XLEN-1:0]      val
);

  // Walk from oldest to youngest so the youngest match overwrites.
  always_comb begin
    val = reg_val;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_dst[i*RIDX +: RIDX] == src) && (src != '0)) begin
        val = fwd_data[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Execute-stage operand unit: forwarding, operand select, and an output register
// backed by a one-entry skid buffer under a valid/ready handshake.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 6,
  parameter int RIDX = 5,
  parameter int NFWD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       E_op,
  input  logic [XLEN-1:0]      E_valA,
  input  logic [XLEN-1:0]      E_valB,
  input  logic [XLEN-1:0]      E_valC,
  input  logic [RIDX-1:0]      E_srcA,
  input  logic [RIDX-1:0]      E_srcB,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RIDX-1:0] fwd_dst,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      e_aluA,
  output logic [XLEN-1:0]      e_aluB,
  output logic [OPW-1:0]       e_op
);

  logic [XLEN-1:0]    fwd_a, fwd_b, new_a, new_b;
  logic [OPW_DEF-1:0] op_dec;
  logic               skid_valid;
  logic [XLEN-1:0]    skid_a, skid_b;
  logic [OPW-1:0]     skid_op;
  logic               accept, out_move;

  operand_fwd_mux #(.XLEN(XLEN), .RIDX(RIDX), .NFWD(NFWD)) u_fwd_a (
    .src(E_srcA), .reg_val(E_valA), .fwd_valid(fwd_valid),
    .fwd_dst(fwd_dst), .fwd_data(fwd_data), .val(fwd_a)
  );

  operand_fwd_mux #(.XLEN(XLEN), .RIDX(RIDX), .NFWD(NFWD)) u_fwd_b (
    .src(E_srcB), .reg_val(E_valB), .fwd_valid(fwd_valid),
    .fwd_dst(fwd_dst), .fwd_data(fwd_data), .val(fwd_b)
  );

  always_comb begin
    op_dec = OPW_DEF'(E_op);
    new_a  = E_valC;
    new_b  = E_valC;
    case (sel_a(op_dec))
      SEL_REG:  new_a = fwd_a;
      SEL_ZERO: new_a = '0;
      default:  new_a = E_valC;
    endcase
    case (sel_b(op_dec))
      SEL_REG:  new_b = fwd_b;
      SEL_ZERO: new_b = '0;
      default:  new_b = E_valC;
    endcase
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign out_move = !out_valid || out_ready;

  // A pending skid entry always drains before new input; in_ready is low then, so no accept races it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      e_aluA     <= '0;
      e_aluB     <= '0;
      e_op       <= '0;
      skid_a     <= '0;
      skid_b     <= '0;
      skid_op    <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_move) begin
      if (skid_valid) begin
        e_aluA     <= skid_a;
        e_aluB     <= skid_b;
        e_op       <= skid_op;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        e_aluA    <= new_a;
        e_aluB    <= new_b;
        e_op      <= E_op;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_a     <= new_a;
      skid_b     <= new_b;
      skid_op    <= E_op;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench: vector table plus stall/flush/reset sequences, scoreboarded against a FIFO model.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int OPW  = 6;
  localparam int RIDX = 5;
  localparam int NFWD = 2;

  logic                 clk = 1'b0;
  logic                 rst, flush, in_valid, out_ready;
  logic                 in_ready, out_valid;
  logic [OPW-1:0]       E_op, e_op;
  logic [XLEN-1:0]      E_valA, E_valB, E_valC, e_aluA, e_aluB;
  logic [RIDX-1:0]      E_srcA, E_srcB;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD*RIDX-1:0] fwd_dst;
  logic [NFWD*XLEN-1:0] fwd_data;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(XLEN), .OPW(OPW), .RIDX(RIDX), .NFWD(NFWD)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .E_op(E_op), .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_srcA(E_srcA), .E_srcB(E_srcB), .fwd_valid(fwd_valid), .fwd_dst(fwd_dst),
    .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .e_aluA(e_aluA), .e_aluB(e_aluB), .e_op(e_op)
  );

  typedef struct {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [OPW-1:0]  op;
  } exp_t;

  typedef struct {
    string           name;
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] val_a, val_b, val_c;
    logic [RIDX-1:0] src_a, src_b;
    logic [1:0]      fv;
    logic [RIDX-1:0] dst0, dst1;
    logic [XLEN-1:0] data0, data1;
    logic [XLEN-1:0] exp_a, exp_b;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic zero_exp = 1'b0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_fwd(input logic [RIDX-1:0] s, input logic [XLEN-1:0] rv);
    logic [XLEN-1:0] r;
    r = rv;
    if (s != 0) begin
      if (fwd_valid[0] && fwd_dst[4:0] == s)      r = fwd_data[31:0];
      else if (fwd_valid[1] && fwd_dst[9:5] == s) r = fwd_data[63:32];
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] ref_a();
    if (E_op == OP_IROP) return ref_fwd(E_srcA, E_valA);
    if (E_op == OP_IJ)   return '0;
    return E_valC;
  endfunction

  function automatic logic [XLEN-1:0] ref_b();
    if (E_op == OP_IROP || E_op == OP_BEQ || E_op == OP_BNE) return ref_fwd(E_srcB, E_valB);
    if (E_op == OP_IJ) return '0;
    return E_valC;
  endfunction

  task automatic check_state();
    chk("out_valid", {31'b0, out_valid}, {31'b0, (sb.size() > 0)});
    chk("in_ready",  {31'b0, in_ready},  {31'b0, (sb.size() < 2)});
    if (sb.size() > 0) begin
      chk("e_aluA", e_aluA, sb[0].a);
      chk("e_aluB", e_aluB, sb[0].b);
      chk("e_op",   {26'b0, e_op}, {26'b0, sb[0].op});
    end
    if (zero_exp) begin
      chk("rst_aluA", e_aluA, '0);
      chk("rst_aluB", e_aluB, '0);
      chk("rst_op",   {26'b0, e_op}, '0);
    end
  endtask

  // One clock: check current state, advance the FIFO model across the edge.
  task automatic cycle(input logic [XLEN-1:0] ea, input logic [XLEN-1:0] eb);
    logic           acc, drn, clr;
    logic [OPW-1:0] op;
    check_state();
    acc = in_valid && (sb.size() < 2);
    drn = out_ready && (sb.size() > 0);
    clr = rst || flush;
    op  = E_op;
    @(posedge clk);
    #1;
    if (clr) sb.delete();
    else begin
      if (drn) void'(sb.pop_front());
      if (acc) sb.push_back('{a: ea, b: eb, op: op});
    end
    zero_exp = rst;
  endtask

  task automatic drive_imm(input logic [XLEN-1:0] tag);
    E_op = OP_ADDI; E_valA = 32'h1; E_valB = 32'h2; E_valC = tag;
    E_srcA = 5'd1; E_srcB = 5'd2; fwd_valid = 2'b00;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"fwd_prio",   OP_IROP, 32'h11, 32'h22, 32'h99, 5'd3, 5'd4, 2'b11, 5'd3, 5'd3, 32'hAA, 32'hBB, 32'hAA, 32'h22};
    vecs[1] = '{"ij_zero",    OP_IJ,   32'h1,  32'h2,  32'h40, 5'd1, 5'd2, 2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,  32'h0};
    vecs[2] = '{"addi_neg",   OP_ADDI, 32'h5,  32'h6,  32'hFFFF_FFFC, 5'd1, 5'd2, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[3] = '{"r0_nofwd",   OP_IROP, 32'h77, 32'h66, 32'h0,  5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 32'h55, 32'h0,  32'h77, 32'h66};
    vecs[4] = '{"beq_fwd1",   OP_BEQ,  32'h1,  32'h30, 32'h8,  5'd5, 5'd6, 2'b10, 5'd0, 5'd6, 32'h0,  32'hCC, 32'h8,  32'hCC};
    vecs[5] = '{"bne_prio",   OP_BNE,  32'h1,  32'h30, 32'h10, 5'd5, 5'd7, 2'b11, 5'd7, 5'd7, 32'hD0, 32'hD1, 32'h10, 32'hD0};
    vecs[6] = '{"split_fwd",  OP_IROP, 32'h1,  32'h2,  32'h0,  5'd9, 5'd8, 2'b11, 5'd8, 5'd9, 32'hE0, 32'hE1, 32'hE1, 32'hE0};
    vecs[7] = '{"fwd_inval",  OP_IROP, 32'h31, 32'h32, 32'h0,  5'd8, 5'd9, 2'b00, 5'd8, 5'd9, 32'hE0, 32'hE1, 32'h31, 32'h32};
    vecs[8] = '{"ori_imm",    OP_ORI,  32'h1,  32'h2,  32'h1234, 5'd1, 5'd2, 2'b11, 5'd1, 5'd2, 32'hF0, 32'hF1, 32'h1234, 32'h1234};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive_imm(32'h0);
    fwd_dst = '0; fwd_data = '0;

    // Two reset cycles; outputs zero after each.
    @(posedge clk); #1;
    zero_exp = 1'b1;
    cycle('0, '0);
    rst = 1'b0;
    cycle('0, '0);

    foreach (vecs[i]) begin
      E_op = vecs[i].op; E_valA = vecs[i].val_a; E_valB = vecs[i].val_b; E_valC = vecs[i].val_c;
      E_srcA = vecs[i].src_a; E_srcB = vecs[i].src_b; fwd_valid = vecs[i].fv;
      fwd_dst = {vecs[i].dst1, vecs[i].dst0}; fwd_data = {vecs[i].data1, vecs[i].data0};
      in_valid = 1'b1;
      cycle(vecs[i].exp_a, vecs[i].exp_b);
      chk({vecs[i].name, "_model"}, ref_a(), vecs[i].exp_a);
    end
    in_valid = 1'b0;
    cycle('0, '0);
    cycle('0, '0);

    // Stalled stream of four ops; forwarding data keeps changing after each accept.
    begin
      int  tag;
      int  cyc;
      logic will_acc;
      tag = 1; cyc = 0;
      while ((tag <= 4 || sb.size() > 0) && cyc < 40) begin
        out_ready = (cyc >= 3);
        in_valid  = (tag <= 4);
        E_op = OP_IROP; E_srcA = 5'd1; E_srcB = 5'd2; E_valA = 32'h0; E_valB = tag;
        fwd_valid = 2'b01; fwd_dst = {5'd0, 5'd1};
        fwd_data = {32'h0, 32'h100 * tag + cyc};
        will_acc = in_valid && (sb.size() < 2);
        cycle(ref_a(), ref_b());
        if (will_acc) tag++;
        cyc++;
      end
      n_vec++;
      if (tag <= 4 || sb.size() > 0) begin
        n_err++;
        $display("FAIL stream_timeout: got tag %0d pending %0d expected tag 5 pending 0", tag, sb.size());
      end
    end
    in_valid = 1'b0;
    cycle('0, '0);

    // Flush with output and skid full; the input presented during flush is dropped.
    out_ready = 1'b0; in_valid = 1'b1;
    drive_imm(32'h5); cycle(ref_a(), ref_b());
    drive_imm(32'h6); cycle(ref_a(), ref_b());
    flush = 1'b1; drive_imm(32'h7); cycle(ref_a(), ref_b());
    flush = 1'b0; out_ready = 1'b1;
    drive_imm(32'h8); cycle(ref_a(), ref_b());
    in_valid = 1'b0;
    cycle('0, '0);
    cycle('0, '0);

    // Flush on an empty stage with input ready: still dropped.
    in_valid = 1'b1; flush = 1'b1; drive_imm(32'h9); cycle(ref_a(), ref_b());
    flush = 1'b0; in_valid = 1'b0;
    cycle('0, '0);

    // Reset mid-operation clears state and zeroes data.
    out_ready = 1'b0; in_valid = 1'b1;
    drive_imm(32'hA); cycle(ref_a(), ref_b());
    drive_imm(32'hB); cycle(ref_a(), ref_b());
    rst = 1'b1; drive_imm(32'hC); cycle(ref_a(), ref_b());
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle('0, '0);
    in_valid = 1'b1; drive_imm(32'hD); cycle(ref_a(), ref_b());
    in_valid = 1'b0;
    cycle('0, '0);
    cycle('0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
